// File: rtl/fetch_unit.sv
// Instruction-fetch front end: PC register, BIOS/IMEM addressing, flush and stall hold.
// Optional macro FETCH_PERF_CNT_EN adds fetch_cnt/kill_cnt performance counters.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h4000_0000,
  parameter int          BIOS_AW  = 12,
  parameter int          IMEM_AW  = 14,
  parameter logic [31:0] NOP_INST = 32'h0000_0013
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               stall,
  input  logic [2:0]         PC_sel,
  input  logic [31:0]        alu_target,
  input  logic [31:0]        jal_target,
  input  logic [31:0]        bios_dout,
  input  logic [31:0]        imem_dout,
  output logic [BIOS_AW-1:0] bios_addr,
  output logic [IMEM_AW-1:0] imem_addr,
  output logic [31:0]        fetch_PC,
  output logic [31:0]        instruction,
  output logic               inst_valid,
  output logic               fetch_fault
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0]        fetch_cnt,
  output logic [31:0]        kill_cnt
`endif
);

  typedef enum logic [1:0] {BOOT, RUN, FLUSH} state_t;

  state_t      state_q, state_d;
  logic [31:0] pc_q, pc_d;
  logic [31:0] resp_q, resp_d;
  logic [31:0] hold_q, hold_d;
  logic        stalled_q, stalled_d;
  logic        valid_q, valid_d;
  logic        fault_q, fault_d;
  logic        redirect;
  logic        pc_mapped;
  logic [31:0] pc_next;
  logic [31:0] live_inst;

  assign bios_addr = pc_q[BIOS_AW+1:2];
  assign imem_addr = pc_q[IMEM_AW+1:2];
  assign fetch_PC  = resp_q;
  assign inst_valid  = valid_q;
  assign fetch_fault = fault_q;
  // After the first stalled cycle the memories show mem[PC_reg], not the presented slot.
  assign instruction = stalled_q ? hold_q : live_inst;

  always_comb begin
    pc_next  = pc_q + 32'd4;
    redirect = 1'b0;
    case (PC_sel)
      3'd0: begin
        pc_next  = RESET_PC;
        redirect = 1'b1;
      end
      3'd3: begin
        pc_next  = alu_target & ~32'd1;
        redirect = 1'b1;
      end
      3'd4: begin
        pc_next  = jal_target;
        redirect = 1'b1;
      end
      default: pc_next = pc_q + 32'd4;
    endcase
  end

  always_comb begin
    pc_mapped = (pc_q[31:28] == 4'b0100) || (pc_q[31:28] == 4'b0001);
    live_inst = NOP_INST;
    if (valid_q) begin
      if (resp_q[31:28] == 4'b0100) live_inst = bios_dout;
      else                          live_inst = imem_dout;
    end
  end

  always_comb begin
    pc_d      = pc_q;
    resp_d    = resp_q;
    state_d   = state_q;
    valid_d   = valid_q;
    fault_d   = fault_q;
    stalled_d = stall;
    hold_d    = hold_q;
    if (stall && !stalled_q) hold_d = live_inst;
    if (!stall) begin
      pc_d    = pc_next;
      resp_d  = pc_q;
      state_d = redirect ? FLUSH : RUN;
      valid_d = (state_d == RUN) && pc_mapped;
      fault_d = !pc_mapped;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= BOOT;
      pc_q      <= RESET_PC;
      resp_q    <= RESET_PC;
      hold_q    <= NOP_INST;
      stalled_q <= 1'b0;
      valid_q   <= 1'b0;
      fault_q   <= 1'b0;
    end else begin
      state_q   <= state_d;
      pc_q      <= pc_d;
      resp_q    <= resp_d;
      hold_q    <= hold_d;
      stalled_q <= stalled_d;
      valid_q   <= valid_d;
      fault_q   <= fault_d;
    end
  end

`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt_q, fetch_cnt_d;
  logic [31:0] kill_cnt_q, kill_cnt_d;

  always_comb begin
    fetch_cnt_d = fetch_cnt_q;
    kill_cnt_d  = kill_cnt_q;
    if (valid_q && !stall)              fetch_cnt_d = fetch_cnt_q + 32'd1;
    if ((state_q == FLUSH) && !stall)   kill_cnt_d  = kill_cnt_q + 32'd1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      fetch_cnt_q <= '0;
      kill_cnt_q  <= '0;
    end else begin
      fetch_cnt_q <= fetch_cnt_d;
      kill_cnt_q  <= kill_cnt_d;
    end
  end

  assign fetch_cnt = fetch_cnt_q;
  assign kill_cnt  = kill_cnt_q;
`endif

endmodule

// File: tb/tb_fetch_unit.sv
// Directed bench for fetch_unit: boot, redirect, stall hold, fault and reset.
// Memories are modelled as 1-cycle synchronous reads returning tagged words.
module tb_fetch_unit;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic [2:0]  PC_sel;
  logic [31:0] alu_target;
  logic [31:0] jal_target;
  logic [31:0] bios_dout;
  logic [31:0] imem_dout;
  logic [11:0] bios_addr;
  logic [13:0] imem_addr;
  logic [31:0] fetch_PC;
  logic [31:0] instruction;
  logic        inst_valid;
  logic        fetch_fault;
`ifdef FETCH_PERF_CNT_EN
  logic [31:0] fetch_cnt;
  logic [31:0] kill_cnt;
`endif

  int n_chk  = 0;
  int n_pass = 0;

  localparam logic [31:0] NOP = 32'h0000_0013;

  fetch_unit dut (
    .clk         (clk),
    .rst         (rst),
    .stall       (stall),
    .PC_sel      (PC_sel),
    .alu_target  (alu_target),
    .jal_target  (jal_target),
    .bios_dout   (bios_dout),
    .imem_dout   (imem_dout),
    .bios_addr   (bios_addr),
    .imem_addr   (imem_addr),
    .fetch_PC    (fetch_PC),
    .instruction (instruction),
    .inst_valid  (inst_valid),
    .fetch_fault (fetch_fault)
`ifdef FETCH_PERF_CNT_EN
    ,
    .fetch_cnt   (fetch_cnt),
    .kill_cnt    (kill_cnt)
`endif
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    bios_dout <= 32'hB000_0000 | {20'd0, bios_addr};
    imem_dout <= 32'h1E00_0000 | {18'd0, imem_addr};
  end

  task automatic chk(input string tag, input logic [31:0] got,
                     input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic slot(input string tag, input logic [31:0] pc,
                      input logic [31:0] inst, input logic v,
                      input logic f);
    chk({tag, ".pc"},    fetch_PC, pc);
    chk({tag, ".inst"},  instruction, inst);
    chk({tag, ".valid"}, {31'd0, inst_valid}, {31'd0, v});
    chk({tag, ".fault"}, {31'd0, fetch_fault}, {31'd0, f});
  endtask

  initial begin
    rst = 1'b1; stall = 1'b0; PC_sel = 3'd2;
    alu_target = '0; jal_target = '0;
    #23;
    slot("rst", 32'h4000_0000, NOP, 1'b0, 1'b0);
    chk("rst.baddr", {20'd0, bios_addr}, 32'd0);
    @(negedge clk); rst = 1'b0; #1;
    // cycle 1: BOOT
    chk("c1.baddr", {20'd0, bios_addr}, 32'd0);
    chk("c1.valid", {31'd0, inst_valid}, 32'd0);
    step(); #1;
    chk("c2.baddr", {20'd0, bios_addr}, 32'd1);
    slot("c2", 32'h4000_0000, 32'hB000_0000, 1'b1, 1'b0);
    step(); #1;
    chk("c3.baddr", {20'd0, bios_addr}, 32'd2);
    slot("c3", 32'h4000_0004, 32'hB000_0001, 1'b1, 1'b0);
    step(); PC_sel = 3'd4; jal_target = 32'h1000_0040; #1;
    chk("c4.baddr", {20'd0, bios_addr}, 32'd3);
    slot("c4", 32'h4000_0008, 32'hB000_0002, 1'b1, 1'b0);
    step(); PC_sel = 3'd2; #1;
    chk("c5.iaddr", {18'd0, imem_addr}, 32'h10);
    slot("c5", 32'h4000_000C, NOP, 1'b0, 1'b0);
    step(); PC_sel = 3'd3; alu_target = 32'h4000_0010; #1;
    slot("c6", 32'h1000_0040, 32'h1E00_0010, 1'b1, 1'b0);
    step(); PC_sel = 3'd2; #1;
    chk("c7.valid", {31'd0, inst_valid}, 32'd0);
    step(); stall = 1'b1; #1;
    slot("c8", 32'h4000_0010, 32'hB000_0004, 1'b1, 1'b0);
    chk("c8.baddr", {20'd0, bios_addr}, 32'd5);
    // stall and redirect together: stall must win
    step(); PC_sel = 3'd3; alu_target = 32'h1000_0101; #1;
    slot("c9", 32'h4000_0010, 32'hB000_0004, 1'b1, 1'b0);
    chk("c9.baddr", {20'd0, bios_addr}, 32'd5);
    step(); PC_sel = 3'd2; #1;
    slot("c10", 32'h4000_0010, 32'hB000_0004, 1'b1, 1'b0);
    chk("c10.baddr", {20'd0, bios_addr}, 32'd5);
    step(); stall = 1'b0; #1;
    slot("c11", 32'h4000_0010, 32'hB000_0004, 1'b1, 1'b0);
    step(); PC_sel = 3'd3; alu_target = 32'h1000_0101; #1;
    slot("c12", 32'h4000_0014, 32'hB000_0005, 1'b1, 1'b0);
    step(); PC_sel = 3'd2; #1;
    chk("c13.iaddr", {18'd0, imem_addr}, 32'h40);
    chk("c13.valid", {31'd0, inst_valid}, 32'd0);
    step(); PC_sel = 3'd3; alu_target = 32'h2000_0000; #1;
    slot("c14", 32'h1000_0100, 32'h1E00_0040, 1'b1, 1'b0);
    step(); PC_sel = 3'd2; #1;
    chk("c15.valid", {31'd0, inst_valid}, 32'd0);
    step(); PC_sel = 3'd4; jal_target = 32'h1000_0000; #1;
    slot("c16", 32'h2000_0000, NOP, 1'b0, 1'b1);
    step(); PC_sel = 3'd2; #1;
    slot("c17", 32'h2000_0004, NOP, 1'b0, 1'b1);
    step(); PC_sel = 3'd3; alu_target = 32'h4000_0000; #1;
    slot("c18", 32'h1000_0000, 32'h1E00_0000, 1'b1, 1'b0);
`ifdef FETCH_PERF_CNT_EN
    chk("c18.fcnt", fetch_cnt, 32'd7);
    chk("c18.kcnt", kill_cnt, 32'd5);
`endif
    step(); PC_sel = 3'd2; #1;
    chk("c19.valid", {31'd0, inst_valid}, 32'd0);
    #1 rst = 1'b1; #1;
    slot("rst2", 32'h4000_0000, NOP, 1'b0, 1'b0);
    chk("rst2.baddr", {20'd0, bios_addr}, 32'd0);
`ifdef FETCH_PERF_CNT_EN
    chk("rst2.fcnt", fetch_cnt, 32'd0);
    chk("rst2.kcnt", kill_cnt, 32'd0);
`endif
    @(negedge clk); rst = 1'b0; #1;
    chk("b1.valid", {31'd0, inst_valid}, 32'd0);
    step(); #1;
    slot("b2", 32'h4000_0000, 32'hB000_0000, 1'b1, 1'b0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule

// File: doc/fetch_unit.md
Name: fetch_unit

Overview:
- Instruction-fetch front end; produces the instruction word and its PC consumed by the decode/control stage.
- Consumes the decoder's PC_sel plus redirect targets.
- Owns the PC register and drives addresses to the synchronous BIOS and IMEM read ports.
- Kills the wrong-path slot after taken redirects and holds its output during stalls.

Parameters:
- RESET_PC, 32'h4000_0000, PC loaded on reset (BIOS region).
- BIOS_AW, 12, BIOS word-address width.
- IMEM_AW, 14, IMEM word-address width.
- NOP_INST, 32'h0000_0013, bubble encoding (addi x0,x0,0).

Ports:
- clk  in  1  sole clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- stall  in  1  freeze fetch; hold PC and outputs.
- PC_sel  in  3  next-PC select: 0 reset, 2 PC+4, 3 ALU target, 4 JAL target; others treated as 2.
- alu_target  in  32  branch/JALR target.
- jal_target  in  32  JAL target.
- bios_dout  in  32  BIOS read data; 1-cycle latency.
- imem_dout  in  32  IMEM read data; 1-cycle latency.
- bios_addr  out  BIOS_AW  = PC_reg[BIOS_AW+1:2].
- imem_addr  out  IMEM_AW  = PC_reg[IMEM_AW+1:2].
- fetch_PC  out  32  PC of the presented instruction.
- instruction  out  32  instruction to decode.
- inst_valid  out  1  instruction is architecturally live.
- fetch_fault  out  1  presented PC lies in an unmapped region.

Behaviour:
- Reset (async, immediate):
  - PC_reg=RESET_PC, fetch_PC=RESET_PC, instruction=NOP_INST, inst_valid=0, fetch_fault=0.
  - State=BOOT; hold register cleared.
  - Addresses are combinational from PC_reg, so bios_addr=0 during reset.
- Latency: address issued in cycle N; data selected in cycle N+1; fetch_PC = PC_reg registered one cycle (resp_PC).
- Region decode on resp_PC[31:28]:
  - 4'b0100: BIOS.
  - 4'b0001: IMEM.
  - Other: unmapped. instruction=NOP_INST, inst_valid=0, fetch_fault=1.
- Next PC (when stall=0):
  - PC_sel 2 or undefined: PC_reg+4, 32-bit wrap (32'hFFFF_FFFC+4 = 0).
  - PC_sel 3: {alu_target[31:1],1'b0}.
  - PC_sel 4: jal_target.
  - PC_sel 0: RESET_PC.
- States:
  - BOOT: first cycle after reset release. RESET_PC is issued; no data yet; inst_valid=0. Go to RUN unless stall.
  - RUN: inst_valid=1 for mapped regions. PC_sel in {0,3,4} with stall=0 goes to FLUSH.
  - FLUSH: the returning word belongs to the wrong path. instruction=NOP_INST, inst_valid=0, fetch_PC still reports the killed PC. The new PC is issued this cycle. Go to RUN, or stay in FLUSH if another redirect arrives.
- Stall:
  - On the first stalled cycle, the presented instruction is captured in a hold register.
  - While stall=1: PC_reg, resp_PC, state, inst_valid and fetch_fault are frozen, and instruction is driven from the hold register.
  - Addresses stay at PC_reg, so the memory output on release equals mem[PC_reg]; no refetch is needed.
- Simultaneous stall and redirect: stall wins; PC_sel is ignored that cycle and the redirect is re-presented by decode.
- Redirect on a faulted slot: redirect still taken; fetch_fault clears when the new PC returns mapped.
- Reset mid-stall or mid-flush: reset dominates; the hold register is discarded.

Optional Feature:
- Macro: FETCH_PERF_CNT_EN.
- With the macro defined:
  - Adds outputs fetch_cnt[31:0] (increments each cycle inst_valid=1 and stall=0) and kill_cnt[31:0] (increments each FLUSH-state cycle with stall=0).
  - Both counters are reset to 0 and wrap at 2^32.
- Without it: the ports and counters are absent; the rest of the behaviour is identical.

Test Plan:
- Reset release, PC_sel=2 and no stall for 4 cycles:
  - bios_addr sequences 0,1,2,3.
  - inst_valid=0 in cycle 1, then 1.
  - fetch_PC follows 4000_0000, 4000_0004, 4000_0008.
- Redirect: PC_sel=4 with jal_target=1000_0040 while fetching 4000_0008:
  - Next cycle inst_valid=0 and instruction=0000_0013.
  - imem_addr=0x10.
  - Following cycle fetch_PC=1000_0040, inst_valid=1, data=imem_dout.
- Stall 3 cycles while presenting 4000_0010 with bios_dout toggling:
  - instruction, fetch_PC and bios_addr hold for all 3 cycles.
  - On release, fetch_PC=4000_0014.
- Stall=1 and PC_sel=3 in the same cycle: no redirect, no FLUSH. After release, PC_sel=3 with alu_target=1000_0101 gives imem_addr=0x40 (bit 0 cleared).
- Jump to 2000_0000 via PC_sel=3: next presented slot has fetch_fault=1, inst_valid=0, instruction=NOP.
- Assert rst mid-FLUSH: outputs return to reset values in the same cycle. With FETCH_PERF_CNT_EN defined, fetch_cnt=0 and kill_cnt=0.
